// File: rtl/posit_mult_core.sv
// posit_mult_core: three-stage posit multiply core (scale decode, significand product, normalize)
module posit_mult_core #(
   parameter int N  = 8,
   parameter int es = 2,
   parameter int Bs = 3,
   localparam int MW = N - es,
   localparam int SW = Bs + es + 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            a_sign,
   input  logic            a_zero,
   input  logic            a_nar,
   input  logic            a_rc,
   input  logic [Bs-1:0]   a_regime,
   input  logic [es-1:0]   a_exp,
   input  logic [MW-1:0]   a_mant,
   input  logic            b_sign,
   input  logic            b_zero,
   input  logic            b_nar,
   input  logic            b_rc,
   input  logic [Bs-1:0]   b_regime,
   input  logic [es-1:0]   b_exp,
   input  logic [MW-1:0]   b_mant,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_sign,
   output logic            out_zero,
   output logic            out_nar,
   output logic [SW-1:0]   out_scale,
   output logic [2*MW-1:0] out_frac,
   output logic            out_sticky
);
   logic            en;
   logic            v1_q, v2_q, v3_q;
   logic            sign_a_q, sign_b_q, zero_a_q, zero_b_q, nar_a_q, nar_b_q;
   logic [SW-1:0]   sc_a_q, sc_b_q;
   logic [MW:0]     sig_a_q, sig_b_q;
   logic [2*MW+1:0] prod_q;
   logic [SW-1:0]   sum_q;
   logic            sign2_q, zero2_q, nar2_q;
   logic            sign_q, zero_q, nar_q, sticky_q;
   logic [SW-1:0]   scale_q;
   logic [2*MW-1:0] frac_q;
   logic            sign_d, sticky_d, hi, special;
   logic [SW-1:0]   scale_d;
   logic [2*MW-1:0] frac_d;

   // regime run length and polarity folded with the exponent into one signed scale
   function automatic logic [SW-1:0] scale_f(input logic rc, input logic [Bs-1:0] rg, input logic [es-1:0] ex);
      logic [SW-1:0] k;
      k = {{(SW-Bs){1'b0}}, rg};
      k = rc ? k : -k;
      return (k << es) + {{(SW-es){1'b0}}, ex};
   endfunction

   // the whole pipe moves together; reset forces the output side empty so the input stays open
   assign out_valid  = v3_q && !rst;
   assign en         = !out_valid || out_ready;
   assign in_ready   = en;
   assign out_sign   = sign_q && !rst;
   assign out_zero   = zero_q && !rst;
   assign out_nar    = nar_q && !rst;
   assign out_sticky = sticky_q && !rst;
   assign out_scale  = rst ? '0 : scale_q;
   assign out_frac   = rst ? '0 : frac_q;

   // normalize the product; specials carry no payload
   always_comb begin
      hi       = prod_q[2*MW+1];
      special  = zero2_q || nar2_q;
      sign_d   = sign2_q && !special;
      frac_d   = special ? '0 : hi ? prod_q[2*MW:1] : prod_q[2*MW-1:0];
      sticky_d = !special && hi && prod_q[0];
      scale_d  = special ? '0 : sum_q + SW'(hi);
   end

   // three pipeline stages advancing on the shared enable
   always_ff @(posedge clk) begin
      if (rst) begin
         {v1_q, v2_q, v3_q} <= '0;
         {sign_a_q, sign_b_q, zero_a_q, zero_b_q, nar_a_q, nar_b_q} <= '0;
         {sc_a_q, sc_b_q, sig_a_q, sig_b_q} <= '0;
         {prod_q, sum_q, sign2_q, zero2_q, nar2_q} <= '0;
         {sign_q, zero_q, nar_q, sticky_q, scale_q, frac_q} <= '0;
      end else if (en) begin
         v1_q     <= in_valid;
         sign_a_q <= a_sign;
         sign_b_q <= b_sign;
         zero_a_q <= a_zero;
         zero_b_q <= b_zero;
         nar_a_q  <= a_nar;
         nar_b_q  <= b_nar;
         sc_a_q   <= scale_f(a_rc, a_regime, a_exp);
         sc_b_q   <= scale_f(b_rc, b_regime, b_exp);
         sig_a_q  <= {1'b1, a_mant};
         sig_b_q  <= {1'b1, b_mant};
         v2_q     <= v1_q;
         prod_q   <= {{(MW+1){1'b0}}, sig_a_q} * {{(MW+1){1'b0}}, sig_b_q};
         sum_q    <= sc_a_q + sc_b_q;
         sign2_q  <= sign_a_q ^ sign_b_q;
         nar2_q   <= nar_a_q || nar_b_q;
         zero2_q  <= (zero_a_q || zero_b_q) && !(nar_a_q || nar_b_q);
         v3_q     <= v2_q;
         sign_q   <= sign_d;
         zero_q   <= zero2_q;
         nar_q    <= nar2_q;
         sticky_q <= sticky_d;
         scale_q  <= scale_d;
         frac_q   <= frac_d;
      end
   end
endmodule

// File: tb/tb_posit_mult_core.sv
// tb_posit_mult_core: vector table plus scoreboard bench for the posit multiply core
module tb_posit_mult_core;
   typedef struct packed {
      logic       sign, zero, nar, rc;
      logic [2:0] rg;
      logic [1:0] ex;
      logic [5:0] mant;
   } op_t;
   typedef struct {
      op_t         a, b;
      logic [23:0] exp;
   } vec_t;

   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, out_sign, out_zero, out_nar, out_sticky;
   logic [7:0] out_scale;
   logic [11:0] out_frac;
   op_t a = '0, b = '0;
   logic [23:0] got;
   logic [23:0] sb_q[$];
   int checks = 0, failures = 0, popped = 0;
   vec_t v[12];

   always #5 clk = ~clk;
   assign got = {out_sign, out_zero, out_nar, out_scale, out_frac, out_sticky};

   posit_mult_core dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_sign(a.sign), .a_zero(a.zero), .a_nar(a.nar), .a_rc(a.rc),
      .a_regime(a.rg), .a_exp(a.ex), .a_mant(a.mant),
      .b_sign(b.sign), .b_zero(b.zero), .b_nar(b.nar), .b_rc(b.rc),
      .b_regime(b.rg), .b_exp(b.ex), .b_mant(b.mant),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar),
      .out_scale(out_scale), .out_frac(out_frac), .out_sticky(out_sticky)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic op_t mk(input logic s, z, n, rc, input logic [2:0] rg, input logic [1:0] ex, input logic [5:0] m);
      op_t o;
      o = '{sign: s, zero: z, nar: n, rc: rc, rg: rg, ex: ex, mant: m};
      return o;
   endfunction

   function automatic op_t rnd_op();
      logic [14:0] r;
      op_t o;
      r = 15'($urandom);
      o = r;
      o.zero = 1'b0;
      o.nar = 1'b0;
      return o;
   endfunction

   function automatic logic [23:0] model(input op_t x, input op_t y);
      int sx, sy, s, p;
      logic st;
      logic [7:0] sc;
      logic [11:0] fr;
      if (x.nar || y.nar) return 24'h200000;
      if (x.zero || y.zero) return 24'h400000;
      sx = (x.rc ? int'(x.rg) : -int'(x.rg)) * 4 + int'(x.ex);
      sy = (y.rc ? int'(y.rg) : -int'(y.rg)) * 4 + int'(y.ex);
      s = sx + sy;
      p = (64 + int'(x.mant)) * (64 + int'(y.mant));
      st = 1'b0;
      if (p >= 8192) begin
         st = p[0];
         p = p / 2;
         s++;
      end
      fr = p[11:0];
      sc = s[7:0];
      return {x.sign ^ y.sign, 2'b00, sc, fr, st};
   endfunction

   // scoreboard: every delivered result is matched against the oldest accepted pair
   always @(negedge clk) begin
      if (rst) sb_q.delete();
      else if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got %0h expected none", got);
         end else begin
            chk("result", got, sb_q.pop_front());
            popped++;
         end
      end
   end

   task automatic send(input op_t x, input op_t y, input logic [23:0] e);
      a = x;
      b = y;
      in_valid = 1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 0;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && sb_q.size() > 0; t++) @(posedge clk);
      #1;
      chk("drain", sb_q.size(), 0);
   endtask

   initial begin
      int n, p0;
      logic [23:0] held;
      v[0] = '{mk(0,0,0,1,0,0,0), mk(0,0,0,1,0,0,6'b100000), {3'b000, 8'd0, 12'b100000000000, 1'b0}};
      v[1] = '{mk(0,0,0,1,0,0,6'b100000), mk(0,0,0,1,0,0,6'b100000), {3'b000, 8'd1, 12'b001000000000, 1'b0}};
      v[2] = '{mk(1,0,0,0,2,3,0), mk(0,0,0,1,1,1,0), {3'b100, 8'd0, 12'd0, 1'b0}};
      v[3] = '{mk(1,0,1,1,3,2,5), mk(0,1,0,1,1,1,7), 24'h200000};
      v[4] = '{mk(0,1,0,1,2,1,9), mk(1,0,0,0,3,2,33), 24'h400000};
      v[5] = '{mk(0,0,0,1,0,0,6'b000001), mk(0,0,0,1,0,0,6'b111111), {3'b000, 8'd1, 12'd31, 1'b1}};
      for (int i = 6; i < 12; i++) begin
         v[i].a = rnd_op();
         v[i].b = rnd_op();
         v[i].exp = model(v[i].a, v[i].b);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_outputs", got, 0);
      a = v[0].a;
      b = v[0].b;
      in_valid = 1;
      @(posedge clk);
      #1;
      rst = 0;
      in_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("no_accept_in_reset", out_valid, 0);
      for (int i = 0; i < 12; i++) send(v[i].a, v[i].b, v[i].exp);
      drain();
      p0 = popped;
      fork
         for (int i = 0; i < 5; i++) begin
            op_t x, y;
            x = rnd_op();
            y = rnd_op();
            send(x, y, model(x, y));
         end
         begin
            n = 0;
            do begin
               @(posedge clk);
               #1;
               n++;
            end while (!out_valid && n < 20);
            chk("stall_first_valid", out_valid, 1);
            out_ready = 0;
            held = got;
            repeat (3) begin
               @(posedge clk);
               #1;
               chk("stall_in_ready", in_ready, 0);
               chk("stall_valid", out_valid, 1);
               chk("stall_hold", got, held);
            end
            out_ready = 1;
         end
      join
      drain();
      chk("stream_count", popped - p0, 5);
      p0 = popped;
      send(v[1].a, v[1].b, v[1].exp);
      send(v[5].a, v[5].b, v[5].exp);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      chk("post_rst_valid", out_valid, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("flushed", popped - p0, 0);
      send(v[2].a, v[2].b, v[2].exp);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, 2);
      drain();
      chk("after_rst_count", popped - p0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
